bin_to_7seg_seq: RTL and testbench



---
 rtl/bin_to_7seg_seq.sv | 235 +++++++++++++++++++++++
 tb/tb_bin_to_7seg_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_7seg_seq.sv
// -----------------------------------------------------------------------------
// bin_to_7seg_seq
//
// Sequential binary-to-decimal display driver. An unsigned WIDTH-bit value is
// converted to DIGITS BCD digits by shift-add-3 (double dabble), one input bit
// per clock. A start/busy/done handshake controls the conversion. The final
// BCD value, its active-low 7-segment patterns (with optional leading-zero
// blanking) and an overflow flag are registered when done pulses. A free-running
// scanner time-multiplexes the digits onto a common-anode display.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request a conversion of bin (ignored while busy)
//   bin       in   [WIDTH-1:0] value, captured on the accepting edge
//   busy      out  conversion in progress
//   done      out  one-cycle pulse; bcd/seg_all/overflow updated in that cycle
//   overflow  out  value did not fit in DIGITS digits (bcd = value mod 10^DIGITS)
//   bcd       out  [4*DIGITS-1:0] BCD result, digit 0 (ones) in bits [3:0]
//   seg_all   out  [7*DIGITS-1:0] segments per digit, {g,f,e,d,c,b,a}, active-low
//   scan_seg  out  [6:0] segments of the currently scanned digit
//   scan_an   out  [DIGITS-1:0] one-hot active-low digit enable
// -----------------------------------------------------------------------------
module bin_to_7seg_seq #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 1,
  parameter int SCAN_DIV = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg_all,
  output logic [6:0]            scan_seg,
  output logic [DIGITS-1:0]     scan_an
);

  localparam int BW = 4 * DIGITS;
  localparam int SEGW = 7 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Active-low pattern for one BCD digit; non-decimal codes go dark.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Conversion state
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    work_q, work_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wovf_q, wovf_d;

  // Registered results
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [SEGW-1:0]  seg_q, seg_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // Scanner
  logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        sseg_q, sseg_d;

  // One double-dabble step: add 3 to every digit >= 5, then shift the
  // concatenated {digits, binary} register left by one.
  logic [BW-1:0]          adj;
  logic [BW+WIDTH-1:0]    cat_sh;
  logic [BW-1:0]          work_sh;
  logic [WIDTH-1:0]       shift_sh;
  logic                   out_bit;
  logic [SEGW-1:0]        seg_new;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (work_q[4*gi +: 4] >= 4'd5) ?
                              (work_q[4*gi +: 4] + 4'd3) : work_q[4*gi +: 4];
    end
  endgenerate

  assign cat_sh   = {adj, shift_q} << 1;
  assign work_sh  = cat_sh[BW+WIDTH-1:WIDTH];
  assign shift_sh = cat_sh[WIDTH-1:0];
  // Bit pushed out of the most significant digit: value exceeds DIGITS digits.
  assign out_bit  = adj[BW-1];

  // Segment patterns of the value produced by this step. Walking from the top
  // digit down, a digit is blank while every digit from it upward is zero;
  // the ones digit always shows.
  always_comb begin
    logic higher_nz;
    seg_new   = '1;
    higher_nz = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      higher_nz = higher_nz | (work_sh[4*k +: 4] != 4'd0);
      if ((BLANK_LZ != 0) && (k != 0) && !higher_nz) begin
        seg_new[7*k +: 7] = 7'b1111111;
      end else begin
        seg_new[7*k +: 7] = seg7(work_sh[4*k +: 4]);
      end
    end
  end

  // Next-state and datapath for the conversion FSM.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    wovf_d  = wovf_q;
    bcd_d   = bcd_q;
    seg_d   = seg_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = bin;
          work_d  = '0;
          cnt_d   = CW'(WIDTH);
          wovf_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = shift_sh;
        work_d  = work_sh;
        wovf_d  = wovf_q | out_bit;
        cnt_d   = cnt_q - CW'(1);
        // Last bit: publish the result straight from this step's value.
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          bcd_d   = work_sh;
          seg_d   = seg_new;
          ovf_d   = wovf_q | out_bit;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scanner: hold each digit SCAN_DIV cycles; enables and segments are
  // registered from the current index, so they trail the index by a cycle.
  always_comb begin
    scan_cnt_d = scan_cnt_q + SW'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
    an_d   = ~(DIGITS'(1) << idx_q);
    sseg_d = 7'b1111111;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        sseg_d = seg_q[7*k +: 7];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      wovf_q  <= 1'b0;
      bcd_q   <= '0;
      seg_q   <= '1;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      wovf_q  <= wovf_d;
      bcd_q   <= bcd_d;
      seg_q   <= seg_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      an_q       <= ~(DIGITS'(1));
      sseg_q     <= 7'b1111111;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      sseg_q     <= sseg_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign bcd      = bcd_q;
  assign seg_all  = seg_q;
  assign scan_seg = sseg_q;
  assign scan_an  = an_q;

endmodule

// File: tb/tb_bin_to_7seg_seq.sv
// -----------------------------------------------------------------------------
// Testbench for bin_to_7seg_seq. Two instances share the stimulus:
//   u0: WIDTH=8, DIGITS=3, BLANK_LZ=1, SCAN_DIV=4
//   u1: WIDTH=8, DIGITS=2, BLANK_LZ=0, SCAN_DIV=1 (exercises overflow)
// A reference model computes digits with decimal arithmetic at each accepted
// start and pushes the expected result into a queue; a monitor pops on done.
// -----------------------------------------------------------------------------
module tb_bin_to_7seg_seq;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic [7:0] bin = 8'd0;

  logic busy0, done0, ovf0;
  logic [11:0] bcd0;
  logic [20:0] seg0;
  logic [6:0] sseg0;
  logic [2:0] an0;

  logic busy1, done1, ovf1;
  logic [7:0] bcd1;
  logic [13:0] seg1;
  logic [6:0] sseg1;
  logic [1:0] an1;

  bin_to_7seg_seq #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1), .SCAN_DIV(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy0), .done(done0), .overflow(ovf0), .bcd(bcd0),
    .seg_all(seg0), .scan_seg(sseg0), .scan_an(an0)
  );

  bin_to_7seg_seq #(.WIDTH(8), .DIGITS(2), .BLANK_LZ(0), .SCAN_DIV(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy1), .done(done1), .overflow(ovf1), .bcd(bcd1),
    .seg_all(seg1), .scan_seg(sseg1), .scan_an(an1)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Decimal reference: digits of v mod 10^nd, blanking digits above the
  // most significant nonzero one when requested.
  function automatic void ref_model(input int v, input int nd, input bit blank,
                                    output logic [19:0] b, output logic [34:0] s,
                                    output logic ovf);
    int lim, r, p, d;
    lim = 1;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    ovf = (v >= lim);
    r = v % lim;
    b = '0;
    s = '1;
    p = 1;
    for (int k = 0; k < nd; k++) begin
      d = (r / p) % 10;
      b[4*k +: 4] = 4'(d);
      s[7*k +: 7] = (blank && k > 0 && r < p) ? 7'b1111111 : seg_of(d);
      p = p * 10;
    end
  endfunction

  typedef struct {
    logic [11:0] bcd;
    logic [20:0] seg;
    logic        ovf;
  } e0_t;
  typedef struct {
    logic [7:0]  bcd;
    logic [13:0] seg;
    logic        ovf;
  } e1_t;

  e0_t q0[$];
  e1_t q1[$];

  // Model state
  int          m_busy = 0;
  int          n_edges = 0;
  logic        exp_done = 1'b0;
  logic [20:0] m_seg0 = '1;
  logic [20:0] pend_seg0 = '1;
  logic [13:0] m_seg1 = '1;
  logic [13:0] pend_seg1 = '1;
  logic [2:0]  exp_an0 = 3'b110;
  logic [6:0]  exp_sseg0 = 7'b1111111;
  logic [1:0]  exp_an1 = 2'b10;
  logic [6:0]  exp_sseg1 = 7'b1111111;

  // Stimulus-side model: decides acceptance from its own busy timer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0;
      n_edges = 0;
      exp_done = 1'b0;
      m_seg0 = '1;
      m_seg1 = '1;
      q0.delete();
      q1.delete();
      exp_an0 = 3'b110;
      exp_sseg0 = 7'b1111111;
      exp_an1 = 2'b10;
      exp_sseg1 = 7'b1111111;
    end else begin
      int i0, i1;
      logic [19:0] b;
      logic [34:0] s;
      logic o;
      e0_t e0;
      e1_t e1;
      // Scanned digit before this edge = floor(edges / SCAN_DIV) mod DIGITS.
      i0 = (n_edges / 4) % 3;
      i1 = n_edges % 2;
      exp_an0 = ~(3'b001 << i0);
      exp_sseg0 = m_seg0[7*i0 +: 7];
      exp_an1 = ~(2'b01 << i1);
      exp_sseg1 = m_seg1[7*i1 +: 7];
      n_edges++;
      exp_done = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          exp_done = 1'b1;
          m_seg0 = pend_seg0;
          m_seg1 = pend_seg1;
        end
      end else if (start) begin
        ref_model(int'(bin), 3, 1'b1, b, s, o);
        e0.bcd = b[11:0]; e0.seg = s[20:0]; e0.ovf = o;
        q0.push_back(e0);
        pend_seg0 = s[20:0];
        ref_model(int'(bin), 2, 1'b0, b, s, o);
        e1.bcd = b[7:0]; e1.seg = s[13:0]; e1.ovf = o;
        q1.push_back(e1);
        pend_seg1 = s[13:0];
        m_busy = W;
      end
    end
  end

  // Monitor: samples on the falling edge, pops the scoreboard on done.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy0", 64'(busy0), 64'(m_busy != 0));
      chk("busy1", 64'(busy1), 64'(m_busy != 0));
      chk("done0", 64'(done0), 64'(exp_done));
      chk("done1", 64'(done1), 64'(exp_done));
      chk("scan_an0", 64'(an0), 64'(exp_an0));
      chk("scan_seg0", 64'(sseg0), 64'(exp_sseg0));
      chk("scan_an1", 64'(an1), 64'(exp_an1));
      chk("scan_seg1", 64'(sseg1), 64'(exp_sseg1));
      if (done0) begin
        if (q0.size() == 0) begin
          chk("q0_pending", 64'(q0.size()), 64'd1);
        end else begin
          e0_t e;
          e = q0.pop_front();
          chk("bcd0", 64'(bcd0), 64'(e.bcd));
          chk("seg_all0", 64'(seg0), 64'(e.seg));
          chk("overflow0", 64'(ovf0), 64'(e.ovf));
          $display("u0 done: bcd=%03h seg=%06h ovf=%0b", bcd0, seg0, ovf0);
        end
      end
      if (done1) begin
        if (q1.size() == 0) begin
          chk("q1_pending", 64'(q1.size()), 64'd1);
        end else begin
          e1_t e;
          e = q1.pop_front();
          chk("bcd1", 64'(bcd1), 64'(e.bcd));
          chk("seg_all1", 64'(seg1), 64'(e.seg));
          chk("overflow1", 64'(ovf1), 64'(e.ovf));
          $display("u1 done: bcd=%02h seg=%04h ovf=%0b", bcd1, seg1, ovf1);
        end
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_busy0"}, 64'(busy0), 64'd0);
    chk({tag, "_done0"}, 64'(done0), 64'd0);
    chk({tag, "_ovf0"}, 64'(ovf0), 64'd0);
    chk({tag, "_bcd0"}, 64'(bcd0), 64'd0);
    chk({tag, "_seg0"}, 64'(seg0), 64'h1FFFFF);
    chk({tag, "_an0"}, 64'(an0), 64'b110);
    chk({tag, "_sseg0"}, 64'(sseg0), 64'h7F);
    chk({tag, "_ovf1"}, 64'(ovf1), 64'd0);
    chk({tag, "_seg1"}, 64'(seg1), 64'h3FFF);
    chk({tag, "_an1"}, 64'(an1), 64'b10);
  endtask

  task automatic convert(input int v);
    @(negedge clk);
    bin = 8'(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin = 8'($urandom);
    repeat (W) @(negedge clk);
  endtask

  initial begin
    int vals[8] = '{255, 7, 0, 105, 200, 42, 99, 100};
    #1 rst_n = 1'b0;
    #2 chk_reset("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (vals[i]) convert(vals[i]);

    // Second start while busy carries a different value and must be ignored.
    @(negedge clk);
    bin = 8'd123;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    bin = 8'd45;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);

    // start held high: conversions run back to back.
    @(negedge clk);
    start = 1'b1;
    repeat (30) begin
      bin = 8'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (10) @(negedge clk);

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    bin = 8'd77;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    convert(42);

    // Random start/bin traffic.
    repeat (400) begin
      start = ($urandom_range(0, 3) == 0);
      bin = 8'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
